// File: rtl/mul_div_stim_gen.sv
// PRNG-driven operand/op-select generator for the floating-point mul/div datapath.
// Runs a programmed number of operations, each offered over a valid/ready handshake.
module mul_div_stim_gen #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16,
  parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [1:0]         sel_mode,
  input  logic [COUNT_W-1:0] num_ops,
  input  logic               abort,
  input  logic               o_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               sel,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] ops_sent
);

  localparam logic [63:0] SEED_INIT = (SEED == 64'h0) ? 64'h1 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t             state;
  logic [63:0]        prng;
  logic [63:0]        s_next;
  logic [1:0]         mode_q;
  logic [1:0]         sel_mode_q;
  logic [COUNT_W-1:0] num_q;
  logic [COUNT_W-1:0] ops_inc;
  logic [WIDTH-1:0]   ra;
  logic [WIDTH-1:0]   rb;
  logic [WIDTH-1:0]   gen_a;
  logic [WIDTH-1:0]   gen_b;
  logic               gen_sel;
  logic               accept;
  logic               last;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] special_val(input logic [1:0] idx);
    logic [WIDTH-1:0] v;
    case (idx)
      2'd0:    v = '0;
      2'd1:    v = WIDTH'(1);
      2'd2:    v = {1'b1, {(WIDTH-1){1'b0}}};
      default: v = '1;
    endcase
    return v;
  endfunction

  // Next operation is always derived from the stepped state, so LOAD and
  // accept-in-SEND share the same generation path.
  always_comb begin
    s_next = xorshift64(prng);
    ra     = s_next[WIDTH-1:0];
    rb     = s_next[63:64-WIDTH];
    gen_a  = ra;
    gen_b  = rb;
    case (mode_q)
      2'd1: if (ra < rb) begin
        gen_a = rb;
        gen_b = ra;
      end
      2'd2: if (ra > rb) begin
        gen_a = rb;
        gen_b = ra;
      end
      2'd3: begin
        gen_a = special_val(s_next[1:0]);
        gen_b = special_val(s_next[3:2]);
      end
      default: ;
    endcase
  end

  always_comb begin
    gen_sel = 1'b0;
    case (sel_mode_q)
      2'd0:    gen_sel = 1'b0;
      2'd1:    gen_sel = 1'b1;
      2'd2:    gen_sel = (state == S_SEND) ? ~sel : 1'b0;
      default: gen_sel = s_next[63];
    endcase
  end

  always_comb begin
    accept  = o_valid & o_ready;
    ops_inc = ops_sent + COUNT_W'(1);
    last    = (ops_inc == num_q);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= S_IDLE;
      prng       <= SEED_INIT;
      mode_q     <= '0;
      sel_mode_q <= '0;
      num_q      <= '0;
      o_valid    <= 1'b0;
      a          <= '0;
      b          <= '0;
      sel        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ops_sent   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            sel_mode_q <= sel_mode;
            num_q      <= num_ops;
            ops_sent   <= '0;
            if (num_ops == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          prng    <= s_next;
          a       <= gen_a;
          b       <= gen_b;
          sel     <= gen_sel;
          o_valid <= 1'b1;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (accept) ops_sent <= ops_inc;
          // A same-cycle accept is counted above before abort ends the run.
          if ((accept && last) || abort) begin
            o_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (accept) begin
            prng <= s_next;
            a    <= gen_a;
            b    <= gen_b;
            sel  <= gen_sel;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_stim_gen.sv
// Self-checking bench for mul_div_stim_gen: directed vector table, handshake
// corner sequences and randomized runs against a spec-level operand model.
module tb_mul_div_stim_gen;

  logic        clk;
  logic        arst;
  logic        start;
  logic [1:0]  mode;
  logic [1:0]  sel_mode;
  logic [15:0] num_ops;
  logic        abort;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic        busy;
  logic        done;
  logic [15:0] ops_sent;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_s;

  mul_div_stim_gen #(
    .WIDTH(32),
    .COUNT_W(16),
    .SEED(64'h0000_0000_0000_0001)
  ) dut (
    .clk(clk),
    .arst(arst),
    .start(start),
    .mode(mode),
    .sel_mode(sel_mode),
    .num_ops(num_ops),
    .abort(abort),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .a(a),
    .b(b),
    .sel(sel),
    .busy(busy),
    .done(done),
    .ops_sent(ops_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Spec-level operand rules: max/min ordering and a special-value lookup.
  function automatic logic [63:0] model_ops(input logic [63:0] s, input logic [1:0] md);
    logic [31:0] ra, rb, lo, hi;
    logic [31:0] sv [4];
    sv[0] = 32'h0; sv[1] = 32'h1; sv[2] = 32'h8000_0000; sv[3] = 32'hFFFF_FFFF;
    ra = s[31:0];
    rb = s[63:32];
    lo = (ra < rb) ? ra : rb;
    hi = (ra < rb) ? rb : ra;
    case (md)
      2'd1:    return {hi, lo};
      2'd2:    return {lo, hi};
      2'd3:    return {sv[s[1:0]], sv[s[3:2]]};
      default: return {ra, rb};
    endcase
  endfunction

  task automatic do_reset();
    arst = 1'b0; start = 1'b0; abort = 1'b0; o_ready = 1'b0;
    mode = 2'd0; sel_mode = 2'd0; num_ops = 16'd0;
    repeat (2) @(negedge clk);
    arst = 1'b1;
    m_s  = 64'h1;
    @(negedge clk);
  endtask

  task automatic run_ops(input logic [1:0] md, input logic [1:0] sm, input int n,
                         input int rdy_pct, input int abort_acc, input int stall_op,
                         input bit noise, output logic [31:0] fa, output logic [31:0] fb,
                         output logic fs);
    int acc = 0;
    int stall = 0;
    int cyc = 0;
    bit have = 0;
    bit fin = 0;
    int exp_acc;
    logic [63:0] ops;
    logic [31:0] ea = '0;
    logic [31:0] eb = '0;
    logic es = 1'b0;
    fa = '0; fb = '0; fs = 1'b0;
    exp_acc = (abort_acc > 0 && abort_acc < n) ? abort_acc : n;
    mode = md; sel_mode = sm; num_ops = 16'(n); start = 1'b1; o_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", o_valid, 0);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
      chk("zero_valid_after", o_valid, 0);
    end else begin
      chk("load_valid", o_valid, 0);
      chk("load_busy", busy, 1);
      chk("load_ops_sent", ops_sent, 0);
      @(negedge clk);
      chk("latency_valid", o_valid, 1);
      while (!fin && cyc < 3000) begin
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (done) begin
          fin = 1;
        end else begin
          chk("valid_hold", o_valid, 1);
          chk("ops_sent_run", ops_sent, 64'(acc));
          if (!have) begin
            m_s = xs(m_s);
            ops = model_ops(m_s, md);
            ea = ops[63:32];
            eb = ops[31:0];
            case (sm)
              2'd0:    es = 1'b0;
              2'd1:    es = 1'b1;
              2'd2:    es = acc[0];
              default: es = m_s[63];
            endcase
            have = 1;
            if (acc == 0) begin fa = a; fb = b; fs = sel; end
          end
          chk("op_a", a, ea);
          chk("op_b", b, eb);
          chk("op_sel", sel, es);
          if (acc == stall_op && stall < 3) begin
            o_ready = 1'b0;
            stall++;
          end else begin
            o_ready = ($urandom_range(0, 99) < rdy_pct);
          end
          if (o_ready) begin
            if (md == 2'd1) chk("a_ge_b", a >= b, 1);
            if (md == 2'd2) chk("b_ge_a", b >= a, 1);
            acc++;
            have = 0;
            if (acc == abort_acc) abort = 1'b1;
          end
          if (noise) begin
            start    = ($urandom_range(0, 3) == 0);
            mode     = 2'($urandom);
            sel_mode = 2'($urandom);
            num_ops  = 16'($urandom);
          end
          @(negedge clk);
        end
      end
      chk("run_timeout", fin, 1);
      chk("accepts", acc, exp_acc);
      chk("ops_sent_end", ops_sent, exp_acc);
      chk("done_valid_low", o_valid, 0);
      chk("done_busy_low", busy, 0);
      start = 1'b0; abort = 1'b0; o_ready = 1'b0;
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      chk("idle_valid_low", o_valid, 0);
      chk("ops_sent_hold", ops_sent, exp_acc);
    end
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [1:0]  sm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        es;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] fa, fb;
    logic fs;
    vecs[0] = '{2'd0, 2'd0, 32'h4082_2041, 32'h0, 1'b0};
    vecs[1] = '{2'd2, 2'd0, 32'h0, 32'h4082_2041, 1'b0};
    vecs[2] = '{2'd1, 2'd0, 32'h4082_2041, 32'h0, 1'b0};
    vecs[3] = '{2'd0, 2'd1, 32'h4082_2041, 32'h0, 1'b1};
    vecs[4] = '{2'd3, 2'd3, 32'h1, 32'h0, 1'b0};
    vecs[5] = '{2'd0, 2'd2, 32'h4082_2041, 32'h0, 1'b0};

    arst = 1'b0; start = 1'b0; abort = 1'b0; o_ready = 1'b0;
    mode = 2'd0; sel_mode = 2'd0; num_ops = 16'd0;
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ops_sent", ops_sent, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_ops(vecs[i].md, vecs[i].sm, 1, 100, 0, -1, 0, fa, fb, fs);
      chk("vec_a", fa, vecs[i].ea);
      chk("vec_b", fb, vecs[i].eb);
      chk("vec_sel", fs, vecs[i].es);
    end

    do_reset();
    run_ops(2'd0, 2'd2, 4, 100, 0, -1, 0, fa, fb, fs);
    run_ops(2'd0, 2'd2, 4, 100, 0, 1, 0, fa, fb, fs);
    run_ops(2'd0, 2'd0, 10, 100, 3, -1, 0, fa, fb, fs);
    run_ops(2'd1, 2'd1, 0, 100, 0, -1, 0, fa, fb, fs);

    // Reset in the middle of a run, then check the sequence restarts from SEED.
    do_reset();
    mode = 2'd0; sel_mode = 2'd0; num_ops = 16'd10; o_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_valid", o_valid, 1);
    chk("mid_ops_sent", ops_sent, 4);
    #2 arst = 1'b0;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_a", a, 0);
    chk("async_b", b, 0);
    chk("async_busy", busy, 0);
    chk("async_ops_sent", ops_sent, 0);
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", done, 0);
    end
    arst = 1'b1;
    m_s  = 64'h1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    run_ops(2'd0, 2'd0, 3, 100, 0, -1, 0, fa, fb, fs);
    chk("reseed_a", fa, 32'h4082_2041);

    run_ops(2'd3, 2'd3, 200, 60, 0, -1, 1, fa, fb, fs);
    run_ops(2'd1, 2'd2, 200, 60, 0, -1, 1, fa, fb, fs);
    run_ops(2'd2, 2'd0, 200, 70, 0, -1, 1, fa, fb, fs);
    run_ops(2'd0, 2'd3, 50, 50, 0, -1, 1, fa, fb, fs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
